// File: rtl/addsub_acc_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor/accumulator.
package addsub_acc_pkg;

    localparam int unsigned MAX_W = 64;

    localparam logic [1:0] MODE_ADD  = 2'd0;
    localparam logic [1:0] MODE_SUB  = 2'd1;
    localparam logic [1:0] MODE_ACC  = 2'd2;
    localparam logic [1:0] MODE_PASS = 2'd3;

    // Largest positive two's-complement value of the given width (0x7F..F).
    function automatic logic [MAX_W-1:0] sat_max(input int unsigned width);
        return (MAX_W'(1) << (width - 32'd1)) - MAX_W'(1);
    endfunction

    // Most negative two's-complement value of the given width (0x80..0).
    function automatic logic [MAX_W-1:0] sat_min(input int unsigned width);
        return MAX_W'(1) << (width - 32'd1);
    endfunction

endpackage

// File: rtl/addsub_sat_core.sv
// Combinational add/subtract with carry, signed-overflow detect and optional saturation.
module addsub_sat_core
    import addsub_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] y_eff;
    logic             c_eff;
    logic [WIDTH:0]   sum;

    // Subtraction is x + ~y + !cin; overflow judged on the effective operands.
    always_comb begin
        y_eff = sub ? ~y : y;
        c_eff = sub ? ~cin : cin;
        sum   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, c_eff};
        cout  = sum[WIDTH];
        ovf   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        res   = sum[WIDTH-1:0];
        if (sat && ovf) begin
            res = x[WIDTH-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
        end
    end

endmodule

// File: rtl/addsub_acc_pipe.sv
// Two-stage valid/ready pipelined adder/subtractor/accumulator with optional saturation.
module addsub_acc_pipe
    import addsub_acc_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SAT    = 0,
    parameter int unsigned ACC_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_data,
    input  logic               in_cin,
    input  logic [1:0]         in_mode,
    input  logic               in_acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_cout,
    output logic               out_ovf
);

    logic en_c;
    logic fire_c;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             s1_cin_q,   s1_cin_d;
    logic [1:0]       s1_mode_q,  s1_mode_d;
    logic             s1_clr_q,   s1_clr_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_cout_q,  out_cout_d;
    logic             out_ovf_q,   out_ovf_d;
    logic [WIDTH-1:0] acc_q,       acc_d;

    logic [WIDTH-1:0] core_x;
    logic [WIDTH-1:0] core_y;
    logic             core_sub;
    logic [WIDTH-1:0] core_res;
    logic             core_cout;
    logic             core_ovf;

    // Whole pipeline advances together whenever the output slot is free or draining.
    always_comb begin
        en_c   = !out_valid_q || out_ready;
        fire_c = in_valid && en_c;
    end

    assign in_ready  = en_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

    // Stage 1 next state: capture the beat on every enabled cycle, valid only on fire.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_cin_d   = s1_cin_q;
        s1_mode_d  = s1_mode_q;
        s1_clr_d   = s1_clr_q;
        if (en_c) begin
            s1_valid_d = fire_c;
            s1_a_d     = in_data[WIDTH-1:0];
            s1_b_d     = in_data[2*WIDTH-1:WIDTH];
            s1_cin_d   = in_cin;
            s1_mode_d  = in_mode;
            s1_clr_d   = in_acc_clr;
        end
    end

    // Operand steering: ACC adds the beat's a onto the (optionally cleared) accumulator.
    always_comb begin
        core_x   = s1_a_q;
        core_y   = s1_b_q;
        core_sub = 1'b0;
        case (s1_mode_q)
            MODE_SUB: core_sub = 1'b1;
            MODE_ACC: begin
                if (ACC_EN != 0) begin
                    core_x = s1_clr_q ? '0 : acc_q;
                    core_y = s1_a_q;
                end else begin
                    core_y = '0;
                end
            end
            default: ;
        endcase
    end

    addsub_sat_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x    (core_x),
        .y    (core_y),
        .cin  (s1_cin_q),
        .sub  (core_sub),
        .sat  (SAT != 0),
        .res  (core_res),
        .cout (core_cout),
        .ovf  (core_ovf)
    );

    // Stage 2 next state: results load only for a valid beat; acc follows ACC results.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        acc_d       = acc_q;
        if (en_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_mode_q == MODE_PASS) begin
                    out_data_d = s1_a_q;
                    out_cout_d = 1'b0;
                    out_ovf_d  = 1'b0;
                end else begin
                    out_data_d = core_res;
                    out_cout_d = core_cout;
                    out_ovf_d  = core_ovf;
                end
                if ((ACC_EN != 0) && (s1_mode_q == MODE_ACC)) begin
                    acc_d = core_res;
                end
            end
        end
    end

    // Pipeline and accumulator registers; synchronous active-low reset drops in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            s1_mode_q   <= MODE_ADD;
            s1_clr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cin_q    <= s1_cin_d;
            s1_mode_q   <= s1_mode_d;
            s1_clr_q    <= s1_clr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Bench for addsub_acc_pipe: a wrapping and a saturating instance share one stimulus stream.
`timescale 1ns/1ps
module tb_addsub_acc_pipe;

    localparam int unsigned W = 16;
    localparam logic [1:0] M_ADD  = 2'd0;
    localparam logic [1:0] M_SUB  = 2'd1;
    localparam logic [1:0] M_ACC  = 2'd2;
    localparam logic [1:0] M_PASS = 2'd3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic [2*W-1:0] in_data = '0;
    logic           in_cin = 1'b0;
    logic [1:0]     in_mode = 2'd0;
    logic           in_acc_clr = 1'b0;
    logic           out_ready = 1'b1;

    logic           in_ready_w, in_ready_s;
    logic           out_valid_w, out_valid_s;
    logic [W-1:0]   out_data_w, out_data_s;
    logic           out_cout_w, out_cout_s;
    logic           out_ovf_w, out_ovf_s;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rdy_rand = 1'b0;

    // Result words are {ovf, cout, data}.
    logic [17:0] exp_w[$];
    logic [17:0] exp_s[$];
    logic [17:0] got_w[$];
    logic [17:0] got_s[$];
    int          got_cyc[$];
    logic [15:0] macc_w = '0;
    logic [15:0] macc_s = '0;

    addsub_acc_pipe #(.WIDTH(W), .SAT(0), .ACC_EN(1)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .in_cin(in_cin), .in_mode(in_mode), .in_acc_clr(in_acc_clr), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_cout(out_cout_w), .out_ovf(out_ovf_w)
    );

    addsub_acc_pipe #(.WIDTH(W), .SAT(1), .ACC_EN(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .in_cin(in_cin), .in_mode(in_mode), .in_acc_clr(in_acc_clr), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_cout(out_cout_s), .out_ovf(out_ovf_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result the consumer accepts at the coming edge.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            if (out_valid_w && out_ready) begin
                got_w.push_back({out_ovf_w, out_cout_w, out_data_w});
                got_cyc.push_back(cyc);
            end
            if (out_valid_s && out_ready) got_s.push_back({out_ovf_s, out_cout_s, out_data_s});
        end
    end

    // Random consumer backpressure when enabled.
    always begin
        @(negedge clk);
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arithmetic on plain integers: exact signed/unsigned results, then range tests.
    function automatic logic [17:0] calc(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                         input logic [1:0] mode, input logic [15:0] base, input bit sat);
        int          usum;
        int          ssum;
        bit          co;
        bit          ov;
        logic [15:0] d;
        if (mode == M_PASS) return {2'b00, a};
        case (mode)
            M_ADD: begin
                usum = int'(a) + int'(b) + int'(cin);
                ssum = int'($signed(a)) + int'($signed(b)) + int'(cin);
                co   = (usum >= 65536);
            end
            M_SUB: begin
                usum = int'(a) - int'(b) - int'(cin);
                ssum = int'($signed(a)) - int'($signed(b)) - int'(cin);
                co   = (usum >= 0);
            end
            default: begin
                usum = int'(base) + int'(a) + int'(cin);
                ssum = int'($signed(base)) + int'($signed(a)) + int'(cin);
                co   = (usum >= 65536);
            end
        endcase
        ov = (ssum > 32767) || (ssum < -32768);
        d  = 16'(usum);
        if (sat && ov) d = (ssum > 0) ? 16'h7FFF : 16'h8000;
        return {ov, co, d};
    endfunction

    task automatic model_accept(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic [1:0] mode, input logic clr);
        logic [17:0] rw;
        logic [17:0] rs;
        rw = calc(a, b, cin, mode, clr ? 16'h0000 : macc_w, 1'b0);
        rs = calc(a, b, cin, mode, clr ? 16'h0000 : macc_s, 1'b1);
        if (mode == M_ACC) begin
            macc_w = rw[15:0];
            macc_s = rs[15:0];
        end
        exp_w.push_back(rw);
        exp_s.push_back(rs);
    endtask

    // Present one beat from the next falling edge and hold it until accepted.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [1:0] mode, input logic clr);
        int n;
        n = 0;
        @(negedge clk);
        in_data = {b, a}; in_cin = cin; in_mode = mode; in_acc_clr = clr; in_valid = 1'b1;
        #1;
        while (!in_ready_w) begin
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout in_ready stuck low for %0d cycles", n);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        model_accept(a, b, cin, mode, clr);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (got_w.size() >= exp_w.size() && got_s.size() >= exp_s.size()) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({out_valid_w, out_cout_w, out_ovf_w, out_data_w} !== 19'h0) begin
            errors++;
            $display("FAIL reset_w out={v%b c%b o%b %h} expected all zero", out_valid_w, out_cout_w, out_ovf_w, out_data_w);
        end
        checks++;
        if ({out_valid_s, out_cout_s, out_ovf_s, out_data_s} !== 19'h0) begin
            errors++;
            $display("FAIL reset_s out={v%b c%b o%b %h} expected all zero", out_valid_s, out_cout_s, out_ovf_s, out_data_s);
        end
        checks++;
        if ({in_ready_w, in_ready_s} !== 2'b11) begin
            errors++;
            $display("FAIL reset_in_ready got %b%b expected 11", in_ready_w, in_ready_s);
        end
        @(negedge clk);
        rst = 1'b1;
        macc_w = '0; macc_s = '0;
    endtask

    task automatic test_add_sub_pass();
        bit ok;
        send(16'hFFFF, 16'h0001, 1'b0, M_ADD, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid_w !== 1'b0) begin
            errors++;
            $display("FAIL latency_early out_valid=%b expected 0 one edge after fire", out_valid_w);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid_w, out_ovf_w, out_cout_w, out_data_w} !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL latency_add v=%b o=%b c=%b d=%h expected v1 o0 c1 0000", out_valid_w, out_ovf_w, out_cout_w, out_data_w);
        end
        send(16'h0005, 16'h0007, 1'b0, M_SUB, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, M_ADD, 1'b0);
        send(16'h1234, 16'hFFFF, 1'b1, M_PASS, 1'b0);
        for (int i = 0; i < 24; i++) begin
            send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)) | (i % 5 == 4 ? 2'd3 : 2'd0), 1'b0);
        end
        idle();
        wait_drain(ok);
        checks++;
        if (!ok || got_w.size() != exp_w.size() || got_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL arith_count got %0d/%0d expected %0d/%0d", got_w.size(), got_s.size(), exp_w.size(), exp_s.size());
        end
        if (got_w.size() >= 4 && got_s.size() >= 4) begin
            checks++;
            if (got_w[1] !== {2'b00, 16'hFFFE}) begin
                errors++; $display("FAIL sub_5_7 got %h expected %h", got_w[1], {2'b00, 16'hFFFE});
            end
            checks++;
            if (got_s[2] !== {2'b10, 16'h7FFF}) begin
                errors++; $display("FAIL sat_add got %h expected %h", got_s[2], {2'b10, 16'h7FFF});
            end
            checks++;
            if (got_w[2] !== {2'b10, 16'h8000}) begin
                errors++; $display("FAIL wrap_add got %h expected %h", got_w[2], {2'b10, 16'h8000});
            end
            checks++;
            if (got_w[3] !== {2'b00, 16'h1234}) begin
                errors++; $display("FAIL pass got %h expected %h", got_w[3], {2'b00, 16'h1234});
            end
        end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++; $display("FAIL arith_w[%0d] got %h expected %h", i, got_w[i], exp_w[i]);
            end
        end
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
            checks++;
            if (got_s[i] !== exp_s[i]) begin
                errors++; $display("FAIL arith_s[%0d] got %h expected %h", i, got_s[i], exp_s[i]);
            end
        end
        exp_w.delete(); exp_s.delete(); got_w.delete(); got_s.delete(); got_cyc.delete();
    endtask

    task automatic test_back_to_back_acc();
        bit ok;
        send(16'd10, 16'($urandom), 1'b0, M_ACC, 1'b1);
        send(16'd20, 16'($urandom), 1'b0, M_ACC, 1'b0);
        send(16'd30, 16'($urandom), 1'b0, M_ACC, 1'b0);
        send(16'd3, 16'd4, 1'b0, M_ADD, 1'b0);
        send(16'd40, 16'($urandom), 1'b0, M_ACC, 1'b0);
        idle();
        wait_drain(ok);
        checks++;
        if (!ok || got_w.size() != 5 || got_s.size() != 5) begin
            errors++;
            $display("FAIL acc_count got %0d/%0d expected 5", got_w.size(), got_s.size());
        end
        if (got_w.size() == 5) begin
            checks++;
            if (got_w[0][15:0] !== 16'd10 || got_w[1][15:0] !== 16'd30 || got_w[2][15:0] !== 16'd60) begin
                errors++;
                $display("FAIL acc_chain got %0d,%0d,%0d expected 10,30,60", got_w[0][15:0], got_w[1][15:0], got_w[2][15:0]);
            end
            checks++;
            if (got_w[4][15:0] !== 16'd100) begin
                errors++; $display("FAIL acc_after_add got %0d expected 100", got_w[4][15:0]);
            end
            checks++;
            if (got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin
                errors++;
                $display("FAIL acc_no_bubble cycles %0d,%0d,%0d expected consecutive", got_cyc[0], got_cyc[1], got_cyc[2]);
            end
        end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++; $display("FAIL acc_w[%0d] got %h expected %h", i, got_w[i], exp_w[i]);
            end
        end
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
            checks++;
            if (got_s[i] !== exp_s[i]) begin
                errors++; $display("FAIL acc_s[%0d] got %h expected %h", i, got_s[i], exp_s[i]);
            end
        end
        exp_w.delete(); exp_s.delete(); got_w.delete(); got_s.delete(); got_cyc.delete();
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          idx;
        logic [15:0] a_v[8];
        logic [15:0] b_v[8];
        logic        c_v[8];
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            a_v[i] = pick_operand(); b_v[i] = pick_operand(); c_v[i] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < 40 && idx < 8; k++) begin
            @(negedge clk);
            out_ready = !(k >= 3 && k <= 5);
            in_data = {b_v[idx], a_v[idx]}; in_cin = c_v[idx]; in_mode = M_ADD; in_acc_clr = 1'b0;
            in_valid = 1'b1;
            #1;
            if (out_valid_w && !out_ready) begin
                checks++;
                if ({in_ready_w, in_ready_s} !== 2'b00) begin
                    errors++; $display("FAIL stall_in_ready cycle %0d got %b%b expected 00", k, in_ready_w, in_ready_s);
                end
            end
            if (in_ready_w) begin
                model_accept(a_v[idx], b_v[idx], c_v[idx], M_ADD, 1'b0);
                idx++;
            end
        end
        idle();
        out_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || idx != 8 || got_w.size() != 8 || got_s.size() != 8) begin
            errors++;
            $display("FAIL bp_count sent %0d got %0d/%0d expected 8", idx, got_w.size(), got_s.size());
        end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++; $display("FAIL bp_w[%0d] got %h expected %h", i, got_w[i], exp_w[i]);
            end
        end
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
            checks++;
            if (got_s[i] !== exp_s[i]) begin
                errors++; $display("FAIL bp_s[%0d] got %h expected %h", i, got_s[i], exp_s[i]);
            end
        end
        exp_w.delete(); exp_s.delete(); got_w.delete(); got_s.delete(); got_cyc.delete();
    endtask

    task automatic test_reset_flush();
        bit ok;
        send(16'd100, 16'h0000, 1'b0, M_ACC, 1'b1);
        send(16'd7, 16'h0000, 1'b0, M_ACC, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_w.delete(); exp_s.delete();
        macc_w = '0; macc_s = '0;
        #1;
        checks++;
        if ({out_valid_w, out_valid_s} !== 2'b00) begin
            errors++; $display("FAIL flush_valid got %b%b expected 00", out_valid_w, out_valid_s);
        end
        @(negedge clk);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (got_w.size() != 0 || got_s.size() != 0) begin
            errors++; $display("FAIL flush_leak got %0d/%0d results expected 0", got_w.size(), got_s.size());
        end
        send(16'd5, 16'h0000, 1'b0, M_ACC, 1'b0);
        idle();
        wait_drain(ok);
        checks++;
        if (!ok || got_w.size() != 1 || got_s.size() != 1) begin
            errors++; $display("FAIL flush_count got %0d/%0d expected 1", got_w.size(), got_s.size());
        end else begin
            checks++;
            if (got_w[0] !== {2'b00, 16'd5} || got_s[0] !== exp_s[0]) begin
                errors++; $display("FAIL flush_acc got %h/%h expected %h", got_w[0], got_s[0], {2'b00, 16'd5});
            end
        end
        exp_w.delete(); exp_s.delete(); got_w.delete(); got_s.delete(); got_cyc.delete();
    endtask

    task automatic test_random();
        bit ok;
        rdy_rand = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0));
        end
        idle();
        wait_drain(ok);
        rdy_rand = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        checks++;
        if (!ok || got_w.size() != exp_w.size() || got_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL rand_count got %0d/%0d expected %0d/%0d", got_w.size(), got_s.size(), exp_w.size(), exp_s.size());
        end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++; $display("FAIL rand_w[%0d] got %h expected %h", i, got_w[i], exp_w[i]);
            end
        end
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
            checks++;
            if (got_s[i] !== exp_s[i]) begin
                errors++; $display("FAIL rand_s[%0d] got %h expected %h", i, got_s[i], exp_s[i]);
            end
        end
        exp_w.delete(); exp_s.delete(); got_w.delete(); got_s.delete(); got_cyc.delete();
    endtask

    initial begin
        test_reset();
        test_add_sub_pass();
        test_back_to_back_acc();
        test_backpressure();
        test_reset_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
